sad_accum_ctrl: RTL and testbench

- Sequencer for the SAD datapath. Accepts a block of pixel pairs, 7 lanes per beat, to match the 7-input compressor width.
- Computes seven per-lane absolute differences and reduces them, with the running total, through one shared compressor-tree stage per beat.
- Presents the final sum of absolute differences on a valid/ready output.
- Sits between the pixel fetch logic and the motion-estimation compare stage.

---
 rtl/sad_accum_ctrl.sv | 81 ++++++++
 tb/tb_sad_accum_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sad_accum_ctrl.sv
// sad_accum_ctrl: sequences 7-lane SAD beats through a diff stage and a saturating accumulate stage.
module sad_accum_ctrl #(
  parameter int PIX_W     = 8,
  parameter int NUM_BEATS = 8,
  parameter int SAD_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7*PIX_W-1:0] cur_pix,
  input  logic [7*PIX_W-1:0] ref_pix,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [SAD_W-1:0]   sad_out,
  output logic               sad_valid,
  input  logic               sad_ready,
  output logic               overflow,
  output logic               busy,
  output logic [7:0]         beat_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [6:0][PIX_W-1:0] diff, d;
  logic s1_valid, ovf, last, accept;
  logic [SAD_W-1:0] acc;
  logic [PIX_W+2:0] beat_sum;
  logic [SAD_W:0] total;
  for (genvar k = 0; k < 7; k++) begin : g_lane
    logic [PIX_W-1:0] c, r;
    assign c = cur_pix[k*PIX_W +: PIX_W];
    assign r = ref_pix[k*PIX_W +: PIX_W];
    assign diff[k] = c >= r ? c - r : r - c;
  end
  // RUN holds one bubble cycle after the last beat so the final diff reaches the accumulator
  assign last      = beat_cnt == 8'(NUM_BEATS);
  assign in_ready  = state == RUN && !last;
  assign accept    = in_valid && in_ready;
  assign busy      = state != IDLE;
  assign sad_valid = state == DONE;
  assign sad_out   = acc;
  assign overflow  = ovf;
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < 7; k++) beat_sum = beat_sum + (PIX_W+3)'(d[k]);
    total = {1'b0, acc} + (SAD_W+1)'(beat_sum);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = last ? DRAIN : RUN;
      DRAIN:   state_n = DONE;
      default: state_n = sad_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      d        <= '0;
      s1_valid <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      s1_valid <= accept;
      if (accept) begin
        d        <= diff;
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (state == IDLE && start) begin
        acc      <= '0;
        ovf      <= 1'b0;
        beat_cnt <= '0;
      end else if (s1_valid) begin
        acc <= total[SAD_W] ? '1 : total[SAD_W-1:0];
        ovf <= ovf | total[SAD_W];
      end
    end
  end
endmodule

// File: tb/tb_sad_accum_ctrl.sv
// tb_sad_accum_ctrl: directed and randomized SAD blocks checked against an integer reference model.
module tb_sad_accum_ctrl;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, sad_ready = 1;
  logic [55:0] cur_pix = '0, ref_pix = '0;
  int sel = 0, tests = 0, fails = 0, cyc = 0;
  logic [7:0] fc [7], fr [7];
  logic [2:0] ir, sv, ov, bz;
  logic [15:0] so0, so1;
  logic [11:0] so2;
  logic [7:0] bc0, bc1, bc2;
  logic in_ready_m, sad_valid_m, overflow_m, busy_m;
  logic [15:0] sad_out_m;
  logic [7:0] beat_cnt_m;

  sad_accum_ctrl #(.PIX_W(8), .NUM_BEATS(8), .SAD_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start && sel == 0), .cur_pix(cur_pix), .ref_pix(ref_pix),
    .in_valid(in_valid), .in_ready(ir[0]), .sad_out(so0), .sad_valid(sv[0]), .sad_ready(sad_ready),
    .overflow(ov[0]), .busy(bz[0]), .beat_cnt(bc0));
  sad_accum_ctrl #(.PIX_W(8), .NUM_BEATS(1), .SAD_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start && sel == 1), .cur_pix(cur_pix), .ref_pix(ref_pix),
    .in_valid(in_valid), .in_ready(ir[1]), .sad_out(so1), .sad_valid(sv[1]), .sad_ready(sad_ready),
    .overflow(ov[1]), .busy(bz[1]), .beat_cnt(bc1));
  sad_accum_ctrl #(.PIX_W(8), .NUM_BEATS(8), .SAD_W(12)) dut2 (
    .clk(clk), .rst(rst), .start(start && sel == 2), .cur_pix(cur_pix), .ref_pix(ref_pix),
    .in_valid(in_valid), .in_ready(ir[2]), .sad_out(so2), .sad_valid(sv[2]), .sad_ready(sad_ready),
    .overflow(ov[2]), .busy(bz[2]), .beat_cnt(bc2));

  always_comb begin
    in_ready_m  = ir[sel];
    sad_valid_m = sv[sel];
    overflow_m  = ov[sel];
    busy_m      = bz[sel];
    sad_out_m   = sel == 0 ? so0 : sel == 1 ? so1 : {4'b0, so2};
    beat_cnt_m  = sel == 0 ? bc0 : sel == 1 ? bc1 : bc2;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input int c, input int r);
    for (int k = 0; k < 7; k++) begin
      fc[k] = 8'(c);
      fr[k] = 8'(r);
    end
  endtask

  // Reference: block SAD is the plain integer sum of |cur-ref| over accepted beats, clipped to the result range.
  task automatic run_block(input int gap, input bit rnd, input bit stall, input string tag);
    int nbk = sel == 1 ? 1 : 8;
    int maxv = sel == 2 ? 4095 : 65535;
    int truth = 0, acc_n = 0, extra = 0, irc = 0, t_last = 0, i = 0, j = 0, bsum, ac, ar;
    logic [7:0] c, r;
    logic [31:0] exp_sad;
    logic exp_ov;
    sad_ready = !stall;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    while (acc_n < nbk && i < 200) begin
      check({tag, "/beat_cnt"}, 32'(beat_cnt_m), 32'(acc_n));
      bsum = 0;
      for (int k = 0; k < 7; k++) begin
        c = rnd ? 8'($urandom) : fc[k];
        r = rnd ? 8'($urandom) : fr[k];
        cur_pix[k*8 +: 8] = c;
        ref_pix[k*8 +: 8] = r;
        ac = int'(c);
        ar = int'(r);
        bsum += ac > ar ? ac - ar : ar - ac;
      end
      in_valid = gap == 0 ? 1'b1 : gap == 1 ? (i % 3 == 0) : ($urandom_range(0, 2) != 0);
      if (in_ready_m) irc++;
      if (in_ready_m && in_valid) begin
        acc_n++;
        truth += bsum;
        t_last = cyc + 1;
      end
      i++;
      @(negedge clk);
    end
    in_valid = 1;
    while (!sad_valid_m && j < 20) begin
      if (in_ready_m) extra++;
      j++;
      @(negedge clk);
    end
    in_valid = 0;
    exp_sad = 32'(truth > maxv ? maxv : truth);
    exp_ov = truth > maxv;
    check({tag, "/sad_valid"}, 32'(sad_valid_m), 1);
    check({tag, "/latency"}, 32'(cyc - t_last), 2);
    check({tag, "/sad_out"}, 32'(sad_out_m), exp_sad);
    check({tag, "/overflow"}, 32'(overflow_m), 32'(exp_ov));
    check({tag, "/final_cnt"}, 32'(beat_cnt_m), 32'(nbk));
    check({tag, "/extra_ready"}, 32'(extra), 0);
    if (gap == 0) check({tag, "/ready_cycles"}, 32'(irc), 32'(nbk));
    if (stall) begin
      for (int k = 0; k < 5; k++) begin
        start = k == 2;
        check({tag, "/hold_valid"}, 32'(sad_valid_m), 1);
        check({tag, "/hold_out"}, 32'(sad_out_m), exp_sad);
        check({tag, "/hold_ovf"}, 32'(overflow_m), 32'(exp_ov));
        @(negedge clk);
      end
      start = 0;
      sad_ready = 1;
    end
    @(negedge clk);
    check({tag, "/valid_drop"}, 32'(sad_valid_m), 0);
    check({tag, "/idle"}, 32'(busy_m), 0);
    check({tag, "/out_held"}, 32'(sad_out_m), exp_sad);
  endtask

  initial begin
    int seen;
    #12;
    check("rst/in_ready", 32'(in_ready_m), 0);
    check("rst/sad_valid", 32'(sad_valid_m), 0);
    check("rst/sad_out", 32'(sad_out_m), 0);
    check("rst/overflow", 32'(overflow_m), 0);
    check("rst/busy", 32'(busy_m), 0);
    check("rst/beat_cnt", 32'(beat_cnt_m), 0);
    @(negedge clk) rst = 0;
    set_lanes(200, 50);
    run_block(0, 0, 0, "b2b");
    set_lanes(1, 0);
    run_block(1, 0, 0, "toggle");
    repeat (4) run_block(2, 1, 0, "rand");
    run_block(2, 1, 1, "stall");
    run_block(0, 1, 0, "fresh");
    // Abort a block after three beats with an asynchronous reset.
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    set_lanes(9, 2);
    for (int k = 0; k < 7; k++) begin
      cur_pix[k*8 +: 8] = fc[k];
      ref_pix[k*8 +: 8] = fr[k];
    end
    in_valid = 1;
    repeat (3) @(negedge clk);
    in_valid = 0;
    check("abort/cnt_before", 32'(beat_cnt_m), 3);
    rst = 1;
    #1;
    check("abort/in_ready", 32'(in_ready_m), 0);
    check("abort/sad_valid", 32'(sad_valid_m), 0);
    check("abort/sad_out", 32'(sad_out_m), 0);
    check("abort/overflow", 32'(overflow_m), 0);
    check("abort/busy", 32'(busy_m), 0);
    check("abort/beat_cnt", 32'(beat_cnt_m), 0);
    @(negedge clk) rst = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (sad_valid_m || busy_m) seen++;
    end
    check("abort/no_result", 32'(seen), 0);
    set_lanes(4, 1);
    run_block(0, 0, 0, "post_rst");
    sel = 1;
    fc = '{8'd0, 8'd255, 8'd10, 8'd100, 8'd7, 8'd128, 8'd3};
    fr = '{8'd255, 8'd0, 8'd20, 8'd90, 8'd7, 8'd127, 8'd9};
    run_block(0, 0, 0, "nb1");
    repeat (3) run_block(2, 1, 0, "nb1_rand");
    sel = 2;
    set_lanes(255, 0);
    run_block(0, 0, 0, "sat");
    repeat (2) run_block(2, 1, 0, "w12_rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
